// File: rtl/mc_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control_pkg
//  Description : Shared encodings for the multi-cycle MIPS control unit:
//                FSM states, OpCode/Funct values, datapath mux selects and
//                the instruction classes produced by the decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package mc_control_pkg;

  // FSM states; values are visible on the debug state port
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  // Instruction classes produced by mc_decode
  typedef enum logic [3:0] {
    C_RTYPE   = 4'd0,
    C_SHIFT   = 4'd1,
    C_IALU    = 4'd2,
    C_LUI     = 4'd3,
    C_LW      = 4'd4,
    C_SW      = 4'd5,
    C_BEQ     = 4'd6,
    C_J       = 4'd7,
    C_JAL     = 4'd8,
    C_JR      = 4'd9,
    C_JALR    = 4'd10,
    C_ILLEGAL = 4'd11
  } instr_class_e;

  // OpCode values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // Funct values for OpCode 00
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  // RegDst selects
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // MemtoReg selects
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // ALUSrcA selects
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // ALUOp selects
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_OPC   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_decode
//  Description : Combinational classifier of OpCode/Funct into an instruction
//                class, plus immediate extension and lui controls.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e cls,
  output logic         ext_op,
  output logic         lu_op
);

  // Map the opcode (and funct for R-type) onto an instruction class
  always_comb begin
    cls = C_ILLEGAL;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL, FN_SRL, FN_SRA:                 cls = C_SHIFT;
          FN_JR:                                  cls = C_JR;
          FN_JALR:                                cls = C_JALR;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU:                        cls = C_RTYPE;
          default:                                cls = C_ILLEGAL;
        endcase
      end
      OP_LW:                                      cls = C_LW;
      OP_SW:                                      cls = C_SW;
      OP_LUI:                                     cls = C_LUI;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI,
      OP_SLTIU:                                   cls = C_IALU;
      OP_BEQ:                                     cls = C_BEQ;
      OP_J:                                       cls = C_J;
      OP_JAL:                                     cls = C_JAL;
      default:                                    cls = C_ILLEGAL;
    endcase
  end

  // Zero-extend for andi and the logical shifts; sign-extend everything else
  always_comb begin
    ext_op = 1'b1;
    if (opcode == OP_ANDI)
      ext_op = 1'b0;
    else if (opcode == OP_RTYPE && (funct == FN_SLL || funct == FN_SRL))
      ext_op = 1'b0;
  end

  assign lu_op = (opcode == OP_LUI);

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mc_control
//  Description : Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) driving the
//                datapath enables and mux selects, with retire and illegal
//                instruction pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module mc_control
  import mc_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal
);

  state_e       state_q;
  state_e       state_d;
  instr_class_e cls;

  mc_decode u_decode (
    .opcode (OpCode),
    .funct  (Funct),
    .cls    (cls),
    .ext_op (ExtOp),
    .lu_op  (LuOp)
  );

  assign state = state_q;

  // State register; reset returns to IF regardless of any pending transition
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_IF;
    else
      state_q <= state_d;
  end

  // Next-state and control outputs; everything held inactive during reset
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RT;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_ID;
          end
        end
        S_ID: begin
          // Branch target is computed here speculatively into ALUOut
          ALUSrcB = SRCB_IMMSH2;
          state_d = S_IF;
          case (cls)
            C_J: begin
              PCWrite    = 1'b1;
              PCSource   = PCSRC_JUMP;
              instr_done = 1'b1;
            end
            C_JAL: begin
              PCWrite    = 1'b1;
              PCSource   = PCSRC_JUMP;
              RegWrite   = 1'b1;
              RegDst     = REGDST_RA;
              MemtoReg   = M2R_PC;
              instr_done = 1'b1;
            end
            C_JR: begin
              PCWrite    = 1'b1;
              PCSource   = PCSRC_RS;
              instr_done = 1'b1;
            end
            C_JALR: begin
              PCWrite    = 1'b1;
              PCSource   = PCSRC_RS;
              RegWrite   = 1'b1;
              RegDst     = REGDST_RD;
              MemtoReg   = M2R_PC;
              instr_done = 1'b1;
            end
            C_ILLEGAL: illegal = 1'b1;
            default:   state_d = S_EX;
          endcase
        end
        S_EX: begin
          ALUSrcA = SRCA_RS;
          state_d = S_IF;
          case (cls)
            C_RTYPE: begin
              ALUOp   = ALUOP_FUNCT;
              state_d = S_WB;
            end
            C_SHIFT: begin
              ALUSrcA = SRCA_SHAMT;
              ALUOp   = ALUOP_FUNCT;
              state_d = S_WB;
            end
            C_IALU, C_LUI: begin
              ALUSrcB = SRCB_IMM;
              ALUOp   = ALUOP_OPC;
              state_d = S_WB;
            end
            C_LW, C_SW: begin
              ALUSrcB = SRCB_IMM;
              state_d = S_MEM;
            end
            C_BEQ: begin
              ALUOp       = ALUOP_SUB;
              PCWriteCond = 1'b1;
              PCWrite     = Zero;
              PCSource    = PCSRC_ALUOUT;
              instr_done  = 1'b1;
            end
            default: state_d = S_IF;
          endcase
        end
        S_MEM: begin
          // Request is held until memory signals completion
          IorD = 1'b1;
          if (cls == C_SW) begin
            MemWrite = 1'b1;
            if (mem_ready) begin
              instr_done = 1'b1;
              state_d    = S_IF;
            end
          end else begin
            MemRead = 1'b1;
            if (mem_ready)
              state_d = S_WB;
          end
        end
        S_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_IF;
          case (cls)
            C_LW:            MemtoReg = M2R_MDR;
            C_RTYPE, C_SHIFT: RegDst  = REGDST_RD;
            default:         RegDst   = REGDST_RT;
          endcase
        end
        default: state_d = S_IF;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mc_control
//  Description : Directed self-checking bench for mc_control.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       Zero, mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic       ExtOp, LuOp, instr_done, illegal;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ExtOp(ExtOp), .LuOp(LuOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .state(state),
    .instr_done(instr_done), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Count cycles from IF until a retire or illegal pulse (inclusive)
  task automatic measure(output int cnt);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cnt++;
      if (instr_done || illegal) begin
        cyc();
        return;
      end
      cyc();
    end
    check("timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; OpCode = 6'h00; Funct = 6'h21; Zero = 1'b0; mem_ready = 1'b1;
    cyc();
    cyc();
    check("rst_state", state, 0);
    check("rst_memread", MemRead, 0);
    check("rst_pcwrite", PCWrite, 0);
    check("rst_irwrite", IRWrite, 0);
    reset = 1'b0;
    #1;
    check("post_rst_state", state, 0);
    check("post_rst_memread", MemRead, 1);

    // addu: IF, ID, EX, WB
    check("addu_if_irw", IRWrite, 1);
    check("addu_if_srcb", ALUSrcB, 1);
    cyc();
    check("addu_id_state", state, 1);
    check("addu_id_srcb", ALUSrcB, 3);
    check("addu_id_pcw", PCWrite, 0);
    cyc();
    check("addu_ex_state", state, 2);
    check("addu_ex_srca", ALUSrcA, 1);
    check("addu_ex_aluop", ALUOp, 2);
    cyc();
    check("addu_wb_state", state, 4);
    check("addu_wb_regw", RegWrite, 1);
    check("addu_wb_regdst", RegDst, 1);
    check("addu_wb_m2r", MemtoReg, 0);
    check("addu_wb_done", instr_done, 1);
    cyc();
    check("addu_back_if", state, 0);

    // lw with two wait cycles in MEM
    OpCode = 6'h23; Funct = 6'h00;
    cyc(); cyc();
    check("lw_ex_state", state, 2);
    check("lw_ex_srcb", ALUSrcB, 2);
    check("lw_ex_aluop", ALUOp, 0);
    mem_ready = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin mem_ready = 1'b1; #1; end
      check("lw_mem_state", state, 3);
      check("lw_mem_rd", MemRead, 1);
      check("lw_mem_iord", IorD, 1);
      check("lw_mem_done", instr_done, 0);
      cyc();
    end
    check("lw_wb_state", state, 4);
    check("lw_wb_m2r", MemtoReg, 1);
    check("lw_wb_regdst", RegDst, 0);
    check("lw_wb_done", instr_done, 1);
    cyc();

    // beq taken then not taken
    OpCode = 6'h04; Zero = 1'b1; #1;
    measure(n);
    check("beq_taken_lat", n, 3);
    Zero = 1'b0;
    cyc(); cyc();
    check("beqn_ex_state", state, 2);
    check("beqn_pcw", PCWrite, 0);
    check("beqn_pcwc", PCWriteCond, 1);
    check("beqn_pcsrc", PCSource, 1);
    check("beqn_aluop", ALUOp, 1);
    Zero = 1'b1; #1;
    check("beq_z_pcw", PCWrite, 1);
    Zero = 1'b0;
    cyc();
    check("beq_back_if", state, 0);

    // jal then jalr
    OpCode = 6'h03; #1;
    cyc();
    check("jal_regw", RegWrite, 1);
    check("jal_m2r", MemtoReg, 2);
    check("jal_regdst", RegDst, 2);
    check("jal_pcsrc", PCSource, 2);
    check("jal_done", instr_done, 1);
    cyc();
    check("jal_back_if", state, 0);
    OpCode = 6'h00; Funct = 6'h09; #1;
    cyc();
    check("jalr_regdst", RegDst, 1);
    check("jalr_pcsrc", PCSource, 3);
    check("jalr_m2r", MemtoReg, 2);
    check("jalr_pcw", PCWrite, 1);
    cyc();
    check("jalr_back_if", state, 0);

    // illegal opcode
    OpCode = 6'h3f; #1;
    cyc();
    check("ill_pulse", illegal, 1);
    check("ill_done", instr_done, 0);
    check("ill_regw", RegWrite, 0);
    check("ill_pcw", PCWrite, 0);
    cyc();
    check("ill_back_if", state, 0);
    check("ill_cleared", illegal, 0);

    // latencies
    OpCode = 6'h2b; #1; measure(n); check("sw_lat", n, 4);
    OpCode = 6'h09; #1; measure(n); check("addiu_lat", n, 4);
    OpCode = 6'h02; #1; measure(n); check("j_lat", n, 2);
    OpCode = 6'h00; Funct = 6'h03; #1; measure(n); check("sra_lat", n, 4);
    Funct = 6'h08; #1; measure(n); check("jr_lat", n, 2);
    OpCode = 6'h23; #1; measure(n); check("lw_lat", n, 5);

    // extension controls
    OpCode = 6'h0c; #1; check("andi_ext", ExtOp, 0); check("andi_lu", LuOp, 0);
    OpCode = 6'h0f; #1; check("lui_ext", ExtOp, 1); check("lui_lu", LuOp, 1);
    OpCode = 6'h00; Funct = 6'h00; #1; check("sll_ext", ExtOp, 0);
    Funct = 6'h02; #1; check("srl_ext", ExtOp, 0);
    Funct = 6'h03; #1; check("sra_ext", ExtOp, 1);
    OpCode = 6'h08; #1; check("addi_ext", ExtOp, 1);

    // reset during sw MEM wait
    OpCode = 6'h2b; #1;
    cyc(); cyc();
    mem_ready = 1'b0;
    cyc();
    check("swr_mem_state", state, 3);
    check("swr_memwrite", MemWrite, 1);
    reset = 1'b1; #1;
    check("swr_rst_memwrite", MemWrite, 0);
    check("swr_rst_done", instr_done, 0);
    cyc();
    check("swr_state_if", state, 0);
    check("swr_memwrite_after", MemWrite, 0);
    check("swr_done_after", instr_done, 0);
    reset = 1'b0; #1;
    check("swr_if_memread", MemRead, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
